// File: rtl/hit_detect_pkg.sv
// Shared game definitions: arena bounds, hit-detect state encoding and the flash colour.
// The HP bar and arena drawing stages import the same values.
package hit_detect_pkg;

    localparam logic [11:0] ARENA_TOP_V    = 12'd367;
    localparam logic [11:0] ARENA_BOTTOM_V = 12'd667;
    localparam logic [11:0] ARENA_LEFT_H   = 12'd361;
    localparam logic [11:0] ARENA_RIGHT_H  = 12'd661;

    localparam logic [7:0]  INVULN_FRAMES_DEFAULT = 8'd60;
    localparam int          BLINK_LOG2_DEFAULT    = 3;
    localparam logic [11:0] BLINK_COLOR_DEFAULT   = 12'hf00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_INVULN = 2'd2
    } hit_state_e;

    // Half-open interval test: lo <= pos < hi.
    function automatic logic in_span(input logic [11:0] pos,
                                     input logic [11:0] lo,
                                     input logic [11:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/hit_detect_frame_edge.sv
// Detects the rising edge of vblnk (frame start) and keeps a free-running 8-bit frame counter;
// exposes the counter bit that sets the flash phase.
module hit_detect_frame_edge
    import hit_detect_pkg::*;
#(
    parameter int BLINK_LOG2 = BLINK_LOG2_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vblnk_i,
    output logic frame_start_o,
    output logic blink_phase_o
);

    logic       vblnk_q;
    logic [7:0] frame_cnt_q;
    logic [7:0] frame_cnt_d;

    assign frame_start_o = vblnk_i && !vblnk_q;
    assign frame_cnt_d   = frame_start_o ? frame_cnt_q + 8'd1 : frame_cnt_q;
    assign blink_phase_o = frame_cnt_q[BLINK_LOG2];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vblnk_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            vblnk_q     <= vblnk_i;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: rtl/hit_detect.sv
// Player/obstacle overlap detector: one player_hit pulse per hit frame, followed by a
// frame-counted invulnerability window during which the player sprite flashes.
module hit_detect
    import hit_detect_pkg::*;
#(
    parameter logic [11:0] TOP_V_LINE    = ARENA_TOP_V,
    parameter logic [11:0] BOTTOM_V_LINE = ARENA_BOTTOM_V,
    parameter logic [11:0] LEFT_H_LINE   = ARENA_LEFT_H,
    parameter logic [11:0] RIGHT_H_LINE  = ARENA_RIGHT_H,
    parameter logic [7:0]  INVULN_FRAMES = INVULN_FRAMES_DEFAULT,
    parameter int          BLINK_LOG2    = BLINK_LOG2_DEFAULT,
    parameter logic [11:0] BLINK_COLOR   = BLINK_COLOR_DEFAULT
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] vcount_in,
    input  logic [11:0] hcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        player_on,
    input  logic        obstacle_on,
    input  logic        game_on,
    output logic [11:0] vcount_out,
    output logic [11:0] hcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out,
    output logic        player_hit,
    output logic        invulnerable
);

    logic frame_start;
    logic blink_phase;

    hit_detect_frame_edge #(
        .BLINK_LOG2(BLINK_LOG2)
    ) u_frame_edge (
        .clk_i         (pclk),
        .rst_ni        (rst),
        .vblnk_i       (vblnk_in),
        .frame_start_o (frame_start),
        .blink_phase_o (blink_phase)
    );

    hit_state_e  state_q, state_d;
    logic        hit_flag_q, hit_flag_d;
    logic [7:0]  inv_cnt_q, inv_cnt_d;
    logic        hit_pulse;
    logic        player_hit_q;
    logic [11:0] rgb_q, rgb_nxt;
    logic [11:0] vcount_q, hcount_q;
    logic        vsync_q, vblnk_q, hsync_q, hblnk_q;

    logic in_arena;
    logic active_px;
    logic collide;

    assign in_arena  = in_span(vcount_in, TOP_V_LINE, BOTTOM_V_LINE) &&
                       in_span(hcount_in, LEFT_H_LINE, RIGHT_H_LINE);
    assign active_px = !hblnk_in && !vblnk_in;
    assign collide   = player_on && obstacle_on && in_arena && active_px;

    // A hit is only accepted on the frame boundary, so the pulse lines up with vblnk_out rising.
    always_comb begin
        state_d    = state_q;
        hit_flag_d = hit_flag_q;
        inv_cnt_d  = inv_cnt_q;
        hit_pulse  = 1'b0;
        if (!game_on) begin
            state_d    = ST_IDLE;
            hit_flag_d = 1'b0;
            inv_cnt_d  = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    hit_flag_d = 1'b0;
                    inv_cnt_d  = 8'd0;
                    state_d    = ST_ARMED;
                end
                ST_ARMED: begin
                    if (frame_start && (hit_flag_q || collide)) begin
                        hit_pulse  = 1'b1;
                        inv_cnt_d  = INVULN_FRAMES;
                        hit_flag_d = 1'b0;
                        state_d    = ST_INVULN;
                    end else if (collide) begin
                        hit_flag_d = 1'b1;
                    end
                end
                ST_INVULN: begin
                    hit_flag_d = 1'b0;
                    if (frame_start) begin
                        if (inv_cnt_q <= 8'd1) begin
                            inv_cnt_d = 8'd0;
                            state_d   = ST_ARMED;
                        end else begin
                            inv_cnt_d = inv_cnt_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hit_flag_d = 1'b0;
                    inv_cnt_d  = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        rgb_nxt = rgb_in;
        if ((state_q == ST_INVULN) && player_on && blink_phase && active_px) begin
            rgb_nxt = BLINK_COLOR;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            hit_flag_q   <= 1'b0;
            inv_cnt_q    <= 8'd0;
            player_hit_q <= 1'b0;
            rgb_q        <= 12'd0;
            vcount_q     <= 12'd0;
            hcount_q     <= 12'd0;
            vsync_q      <= 1'b0;
            vblnk_q      <= 1'b0;
            hsync_q      <= 1'b0;
            hblnk_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hit_flag_q   <= hit_flag_d;
            inv_cnt_q    <= inv_cnt_d;
            player_hit_q <= hit_pulse;
            rgb_q        <= rgb_nxt;
            vcount_q     <= vcount_in;
            hcount_q     <= hcount_in;
            vsync_q      <= vsync_in;
            vblnk_q      <= vblnk_in;
            hsync_q      <= hsync_in;
            hblnk_q      <= hblnk_in;
        end
    end

    assign vcount_out   = vcount_q;
    assign hcount_out   = hcount_q;
    assign vsync_out    = vsync_q;
    assign vblnk_out    = vblnk_q;
    assign hsync_out    = hsync_q;
    assign hblnk_out    = hblnk_q;
    assign rgb_out      = rgb_q;
    assign player_hit   = player_hit_q;
    assign invulnerable = (state_q == ST_INVULN);

endmodule

// File: tb/tb_hit_detect.sv
// Directed bench for hit_detect using short synthetic frames (three active pixels, three
// vblank cycles) and INVULN_FRAMES=3.
module tb_hit_detect;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] vcount_in, hcount_in;
    logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
    logic [11:0] rgb_in;
    logic        player_on, obstacle_on, game_on;
    logic [11:0] vcount_out, hcount_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
    logic [11:0] rgb_out;
    logic        player_hit, invulnerable;

    int n_cmp = 0;
    int n_mis = 0;
    int hits_seen = 0;

    always #5 pclk = ~pclk;

    hit_detect #(
        .INVULN_FRAMES(8'd3)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .vcount_in    (vcount_in),
        .hcount_in    (hcount_in),
        .vsync_in     (vsync_in),
        .vblnk_in     (vblnk_in),
        .hsync_in     (hsync_in),
        .hblnk_in     (hblnk_in),
        .rgb_in       (rgb_in),
        .player_on    (player_on),
        .obstacle_on  (obstacle_on),
        .game_on      (game_on),
        .vcount_out   (vcount_out),
        .hcount_out   (hcount_out),
        .vsync_out    (vsync_out),
        .vblnk_out    (vblnk_out),
        .hsync_out    (hsync_out),
        .hblnk_out    (hblnk_out),
        .rgb_out      (rgb_out),
        .player_hit   (player_hit),
        .invulnerable (invulnerable)
    );

    always @(negedge pclk) begin
        if (player_hit === 1'b1) hits_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic drive(input logic [11:0] v, input logic [11:0] h, input logic hb,
                         input logic vb, input logic pl, input logic ob, input logic [11:0] rgb);
        vcount_in   = v;
        hcount_in   = h;
        hblnk_in    = hb;
        hsync_in    = hb;
        vblnk_in    = vb;
        vsync_in    = vb;
        player_on   = pl;
        obstacle_on = ob;
        rgb_in      = rgb;
        step();
    endtask

    task automatic pixel_check(input string tag, input logic [11:0] v, input logic [11:0] h,
                               input logic hb, input logic pl, input logic ob,
                               input logic [11:0] rgb, input logic [11:0] exp_rgb);
        drive(v, h, hb, 1'b0, pl, ob, rgb);
        check_eq(tag, {20'd0, rgb_out}, {20'd0, exp_rgb});
    endtask

    // One frame: three active pixels (the middle one may carry an overlap), then vblank.
    task automatic run_frame(input string tag, input logic ovl, input logic [11:0] ov,
                             input logic [11:0] oh, input logic ohb,
                             input logic exp_hit, input logic exp_inv);
        drive(12'd400, 12'd400, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
        drive(ov, oh, ohb, 1'b0, ovl, ovl, 12'h222);
        drive(12'd400, 12'd401, 1'b0, 1'b0, 1'b0, 1'b0, 12'h333);
        drive(12'd700, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        check_eq({tag, "_hit"}, {31'd0, player_hit}, {31'd0, exp_hit});
        check_eq({tag, "_vblnk_out"}, {31'd0, vblnk_out}, 32'd1);
        drive(12'd700, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        check_eq({tag, "_inv"}, {31'd0, invulnerable}, {31'd0, exp_inv});
        drive(12'd701, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        rst = 1'b0;
        game_on = 1'b0;
        vcount_in = 12'd0; hcount_in = 12'd0;
        vsync_in = 1'b0; vblnk_in = 1'b0; hsync_in = 1'b0; hblnk_in = 1'b0;
        rgb_in = 12'd0; player_on = 1'b0; obstacle_on = 1'b0;

        // Reset held for 3 cycles with busy inputs
        for (int i = 0; i < 3; i++) drive(12'd5, 12'd6, 1'b1, 1'b0, 1'b1, 1'b1, 12'hfff);
        check_eq("rst_timing", {4'd0, vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out}, 32'd0);
        check_eq("rst_rgb", {20'd0, rgb_out}, 32'd0);
        check_eq("rst_hit", {31'd0, player_hit}, 32'd0);
        check_eq("rst_inv", {31'd0, invulnerable}, 32'd0);

        // Game off: plain 1-cycle pass-through, no hits
        rst = 1'b1;
        pixel_check("pass_rgb", 12'd400, 12'd399, 1'b0, 1'b0, 1'b0, 12'h123, 12'h123);
        check_eq("pass_vcount", {20'd0, vcount_out}, 32'd400);
        check_eq("pass_hcount", {20'd0, hcount_out}, 32'd399);
        pixel_check("pass_player", 12'd400, 12'd400, 1'b0, 1'b1, 1'b0, 12'habc, 12'habc);
        run_frame("off", 1'b1, 12'd400, 12'd400, 1'b0, 1'b0, 1'b0);

        // Hit, then three invulnerable frames with overlap every frame, then second hit
        game_on = 1'b1;
        run_frame("hit1", 1'b1, 12'd400, 12'd400, 1'b0, 1'b1, 1'b1);
        run_frame("inv_a", 1'b1, 12'd400, 12'd400, 1'b0, 1'b0, 1'b1);
        run_frame("inv_b", 1'b1, 12'd400, 12'd400, 1'b0, 1'b0, 1'b1);
        run_frame("inv_c", 1'b1, 12'd400, 12'd400, 1'b0, 1'b0, 1'b0);
        run_frame("hit2", 1'b1, 12'd400, 12'd400, 1'b0, 1'b1, 1'b1);

        // Flash: frame_cnt=6 (bit3 clear), then frame_cnt=8 (bit3 set)
        pixel_check("blink_off", 12'd400, 12'd400, 1'b0, 1'b1, 1'b0, 12'h0f0, 12'h0f0);
        run_frame("bl1", 1'b0, 12'd400, 12'd400, 1'b0, 1'b0, 1'b1);
        run_frame("bl2", 1'b0, 12'd400, 12'd400, 1'b0, 1'b0, 1'b1);
        pixel_check("blink_on", 12'd400, 12'd402, 1'b0, 1'b1, 1'b0, 12'h0f0, 12'hf00);
        pixel_check("blink_hblnk", 12'd400, 12'd403, 1'b1, 1'b1, 1'b0, 12'h0f0, 12'h0f0);
        pixel_check("blink_noplayer", 12'd400, 12'd404, 1'b0, 1'b0, 1'b0, 12'h0ab, 12'h0ab);
        run_frame("bl3", 1'b0, 12'd400, 12'd400, 1'b0, 1'b0, 1'b0);
        pixel_check("armed_noblink", 12'd400, 12'd400, 1'b0, 1'b1, 1'b0, 12'h0f0, 12'h0f0);

        // Overlaps outside the arena, on exclusive bounds, or in hblnk: no hit
        run_frame("out_h300", 1'b1, 12'd400, 12'd300, 1'b0, 1'b0, 1'b0);
        run_frame("in_hblnk", 1'b1, 12'd400, 12'd400, 1'b1, 1'b0, 1'b0);
        run_frame("out_v667", 1'b1, 12'd667, 12'd400, 1'b0, 1'b0, 1'b0);
        run_frame("out_h661", 1'b1, 12'd400, 12'd661, 1'b0, 1'b0, 1'b0);
        run_frame("edge_hit", 1'b1, 12'd666, 12'd660, 1'b0, 1'b1, 1'b1);

        // Drop game_on mid-invulnerability, and drop a pending hit flag
        game_on = 1'b0;
        drive(12'd400, 12'd400, 1'b0, 1'b0, 1'b0, 1'b1, 12'h055);
        check_eq("drop_inv", {31'd0, invulnerable}, 32'd0);
        drive(12'd400, 12'd401, 1'b0, 1'b0, 1'b1, 1'b1, 12'h055);
        game_on = 1'b1;
        drive(12'd400, 12'd402, 1'b0, 1'b0, 1'b0, 1'b0, 12'h055);
        check_eq("rearm_inv", {31'd0, invulnerable}, 32'd0);
        drive(12'd400, 12'd403, 1'b0, 1'b0, 1'b1, 1'b1, 12'h055);
        game_on = 1'b0;
        drive(12'd400, 12'd404, 1'b0, 1'b0, 1'b0, 1'b0, 12'h055);
        game_on = 1'b1;
        run_frame("stale", 1'b0, 12'd400, 12'd400, 1'b0, 1'b0, 1'b0);
        run_frame("corner", 1'b1, 12'd367, 12'd361, 1'b0, 1'b1, 1'b1);

        // Reset mid-invulnerability, then reset after a collision in ARMED
        drive(12'd400, 12'd400, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0aa);
        rst = 1'b0;
        drive(12'd400, 12'd401, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0aa);
        check_eq("rst_mid_inv", {31'd0, invulnerable}, 32'd0);
        check_eq("rst_mid_rgb", {20'd0, rgb_out}, 32'd0);
        rst = 1'b1;
        drive(12'd400, 12'd402, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0aa);
        drive(12'd400, 12'd403, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0aa);
        rst = 1'b0;
        drive(12'd400, 12'd404, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0aa);
        check_eq("rst_mid_hit", {31'd0, player_hit}, 32'd0);
        rst = 1'b1;
        run_frame("post_rst", 1'b0, 12'd400, 12'd400, 1'b0, 1'b0, 1'b0);
        run_frame("final", 1'b1, 12'd400, 12'd400, 1'b0, 1'b1, 1'b1);

        step();
        check_eq("total_hits", hits_seen, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/hit_detect.md
Name: hit_detect

Overview:
- Pixel-pipeline stage directly upstream of the HP bar stage; it generates that stage's player_hit input.
- Watches per-pixel player-sprite and obstacle coverage flags inside the arena and records any overlap during the frame.
- At each frame end, issues a single one-cycle player_hit pulse, then holds an invulnerability window of INVULN_FRAMES frames.
- While invulnerable, flashes the player sprite; timing and rgb are forwarded with 1-cycle latency.

Parameters:
- TOP_V_LINE, 367: arena top row (inclusive)
- BOTTOM_V_LINE, 667: arena bottom row (exclusive)
- LEFT_H_LINE, 361: arena left column (inclusive)
- RIGHT_H_LINE, 661: arena right column (exclusive)
- INVULN_FRAMES, 60: frames of immunity after a hit; legal range 1..255
- BLINK_LOG2, 3: flash toggles every 2^BLINK_LOG2 frames
- BLINK_COLOR, 12'hf_0_0: colour drawn over player pixels in the flash-on phase

Ports:
- pclk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-low reset
- vcount_in, hcount_in  in  12 each  pixel position
- vsync_in, vblnk_in, hsync_in, hblnk_in  in  1 each  timing signals
- rgb_in  in  12  upstream pixel colour
- player_on  in  1  player sprite covers current pixel (aligned with rgb_in)
- obstacle_on  in  1  obstacle covers current pixel (aligned with rgb_in)
- game_on  in  1  game running
- vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out  out  12/12/1/1/1/1  timing delayed 1 cycle
- rgb_out  out  12  pixel colour, 1-cycle latency
- player_hit  out  1  one-cycle pulse per accepted hit
- invulnerable  out  1  high while in state INVULN

Behaviour:
- Reset (rst==0 at a pclk edge): all outputs 0, state IDLE, hit_flag 0, inv_cnt 0, frame_cnt 0, vblnk_d 0.
- Pipeline: every timing output equals its input registered once; rgb_out = rgb_nxt registered.
- frame_start: vblnk_in==1 && vblnk_d==0; vblnk_d is vblnk_in registered.
- frame_cnt (8 bit): increments on every frame_start, wraps at 255 to 0, regardless of state.
- in_arena: TOP_V_LINE<=vcount_in<BOTTOM_V_LINE and LEFT_H_LINE<=hcount_in<RIGHT_H_LINE.
- collide: player_on && obstacle_on && in_arena && !hblnk_in && !vblnk_in.
- State IDLE:
  - hit_flag held 0, player_hit 0, invulnerable 0.
  - game_on==1 -> ARMED; hit_flag stays cleared, so the partial first frame starts clean.
- State ARMED:
  - collide sets hit_flag (sticky).
  - At frame_start with hit_flag==1 (including a collide on that same cycle, though collide is 0 during vblnk): player_hit=1 for exactly that one cycle, so the pulse aligns with the rising edge of vblnk_out. Also load inv_cnt=INVULN_FRAMES, clear hit_flag, go to INVULN.
  - At frame_start with hit_flag==0: stay in ARMED.
- State INVULN:
  - collide ignored; hit_flag forced 0.
  - At each frame_start, inv_cnt decrements. When inv_cnt==1 at that frame_start, go to ARMED; the next full frame is eligible.
  - The hit frame's own frame_start does not decrement; immunity covers exactly INVULN_FRAMES full frames.
- game_on==0 in any state: next state IDLE; inv_cnt and hit_flag cleared; any pending pulse is dropped.
- At most one player_hit per frame, and none while invulnerable.
- rgb_nxt = BLINK_COLOR when state==INVULN && player_on && frame_cnt[BLINK_LOG2]==1 && !hblnk_in && !vblnk_in; otherwise rgb_nxt = rgb_in.
- Reset mid-frame or mid-INVULN: everything returns to reset values on the next edge; no pulse is emitted.

Decomposition:
- Shared game package holds the arena bounds, the state encodings (IDLE/ARMED/INVULN, 2 bit) and BLINK_COLOR; these are shared with the HP bar and arena drawing stages.
- One natural sub-module: frame_edge, which registers vblnk and emits frame_start plus frame_cnt.

Test Plan:
- Reset with rst=0 for 3 cycles -> all outputs 0; with rst=1 and game_on=0 -> rgb_out tracks rgb_in with 1-cycle delay, player_hit never asserts.
- game_on=1; player_on and obstacle_on both high at (h=400, v=400) for one pixel -> exactly one player_hit pulse, coinciding with the next vblnk_out rise; invulnerable=1 from the following cycle.
- Overlap held every frame with INVULN_FRAMES=3 -> hits at frame N and N+4 only; invulnerable is high for frames N+1..N+3.
- Overlap only at (h=300, v=400), outside the arena, or during hblnk -> no player_hit.
- During INVULN, player_on pixels with frame_cnt[3]=1 -> rgb_out=12'hf00; with frame_cnt[3]=0 -> rgb_out=rgb_in.
- Drop game_on mid-INVULN, then reassert -> state ARMED, invulnerable=0, no stale pulse; also rst=0 pulled mid-frame after a collision -> no player_hit.
